// File: rtl/fcvt_sd.sv
// Multi-cycle FP32<->FP64 conversion (FCVT.S.D / FCVT.D.S) with IEEE-754 rounding and flags.
// Subnormal alignment shifts one bit per cycle, so latency depends on the operand.
module fcvt_sd (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        dir_i,
  input  logic [63:0] operand_i,
  input  logic [2:0]  rm_i,
  output logic        busy_o,
  output logic        valid_o,
  output logic [63:0] result_o,
  output logic [4:0]  flags_o
);

  typedef enum logic [2:0] {IDLE, UNPACK, SHIFT, ROUND, DONE} state_t;

  localparam logic [63:0] DNAN = 64'h7FF8000000000000;
  localparam logic [63:0] SNAN = 64'hFFFFFFFF7FC00000;
  localparam logic [4:0]  F_NV = 5'b10000;
  localparam logic [4:0]  F_OF = 5'b00100;
  localparam logic [4:0]  F_NX = 5'b00001;

  state_t             state_reg;
  logic               dir_reg;
  logic [63:0]        op_reg;
  logic [2:0]         rm_reg;
  logic               sign_reg;
  logic signed [12:0] exp_reg;
  logic [52:0]        sig_reg;
  logic               sticky_reg;
  logic [4:0]         cnt_reg;
  logic               special_reg;
  logic [63:0]        spec_res_reg;
  logic [4:0]         spec_flags_reg;
  logic               tiny_reg;

  function automatic logic round_inc(input logic [2:0] rm, input logic sign,
                                     input logic lsb, input logic g, input logic st);
    case (rm)
      3'd1:    return 1'b0;
      3'd2:    return sign & (g | st);
      3'd3:    return ~sign & (g | st);
      3'd4:    return g;
      default: return g & (st | lsb);
    endcase
  endfunction

  // Unpack: exp is held biased in the target format (may go negative when narrowing).
  logic               u_sign, u_special, u_shift, u_tiny;
  logic signed [12:0] u_exp, u_dist;
  logic [52:0]        u_sig;
  logic [63:0]        u_res;
  logic [4:0]         u_flags, u_cnt;

  always_comb begin
    u_sign    = 1'b0;
    u_special = 1'b0;
    u_shift   = 1'b0;
    u_tiny    = 1'b0;
    u_exp     = '0;
    u_dist    = '0;
    u_sig     = '0;
    u_res     = '0;
    u_flags   = '0;
    u_cnt     = '0;
    if (dir_reg) begin
      u_sign = op_reg[31];
      if (op_reg[63:32] != 32'hFFFFFFFF) begin
        u_special = 1'b1;
        u_res     = DNAN;
      end else if (op_reg[30:23] == 8'hFF) begin
        u_special = 1'b1;
        u_res     = (op_reg[22:0] == '0) ? {u_sign, 11'h7FF, 52'b0} : DNAN;
        u_flags   = (op_reg[22:0] != '0 && !op_reg[22]) ? F_NV : 5'b0;
      end else if (op_reg[30:0] == '0) begin
        u_special = 1'b1;
        u_res     = {u_sign, 63'b0};
      end else begin
        u_exp   = (op_reg[30:23] == '0) ? 13'sd897 : $signed({5'b0, op_reg[30:23]}) + 13'sd896;
        u_sig   = {op_reg[30:23] != '0, op_reg[22:0], 29'b0};
        u_shift = (op_reg[30:23] == '0);
      end
    end else begin
      u_sign = op_reg[63];
      if (op_reg[62:52] == 11'h7FF) begin
        u_special = 1'b1;
        u_res     = (op_reg[51:0] == '0) ? {32'hFFFFFFFF, u_sign, 8'hFF, 23'b0} : SNAN;
        u_flags   = (op_reg[51:0] != '0 && !op_reg[51]) ? F_NV : 5'b0;
      end else if (op_reg[62:0] == '0) begin
        u_special = 1'b1;
        u_res     = {32'hFFFFFFFF, u_sign, 31'b0};
      end else begin
        u_exp = (op_reg[62:52] == '0) ? -13'sd895 : $signed({2'b0, op_reg[62:52]}) - 13'sd896;
        u_sig = {op_reg[62:52] != '0, op_reg[51:0]};
        if (u_exp < 13'sd1) begin
          u_shift = 1'b1;
          u_dist  = 13'sd1 - u_exp;
          u_cnt   = (u_dist > 13'sd25) ? 5'd25 : u_dist[4:0];
        end
        // Biased exponent 0 is still not tiny if unbounded rounding carries up to 2^-126.
        u_tiny = (u_exp < 13'sd0) ||
                 (u_exp == 13'sd0 && !(&u_sig[52:29] &&
                  round_inc(rm_reg, u_sign, 1'b1, u_sig[28], |u_sig[27:0])));
      end
    end
  end

  logic        r_g, r_st, r_inc, r_nx, r_ovf, r_to_inf;
  logic [7:0]  r_epre;
  logic [30:0] r_packed;
  logic [63:0] r_res;
  logic [4:0]  r_flags;

  always_comb begin
    r_g      = sig_reg[28];
    r_st     = (|sig_reg[27:0]) | sticky_reg;
    r_inc    = round_inc(rm_reg, sign_reg, sig_reg[29], r_g, r_st);
    r_nx     = r_g | r_st;
    r_epre   = sig_reg[52] ? exp_reg[7:0] : 8'h00;
    // Mantissa carry-out propagates straight into the exponent field.
    r_packed = {r_epre, sig_reg[51:29]} + {30'b0, r_inc};
    r_ovf    = (exp_reg > 13'sd254) || (r_packed[30:23] == 8'hFF);
    r_to_inf = (rm_reg == 3'd0) || (rm_reg == 3'd4) ||
               (rm_reg == 3'd2 && sign_reg) || (rm_reg == 3'd3 && !sign_reg);
    r_res    = '0;
    r_flags  = '0;
    if (dir_reg) begin
      r_res = {sign_reg, exp_reg[10:0], sig_reg[51:0]};
    end else if (r_ovf) begin
      r_res   = {32'hFFFFFFFF, sign_reg, r_to_inf ? {8'hFF, 23'h000000} : {8'hFE, 23'h7FFFFF}};
      r_flags = F_OF | F_NX;
    end else begin
      r_res   = {32'hFFFFFFFF, sign_reg, r_packed};
      r_flags = {3'b000, tiny_reg & r_nx, r_nx};
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg      <= IDLE;
      dir_reg        <= 1'b0;
      op_reg         <= '0;
      rm_reg         <= '0;
      sign_reg       <= 1'b0;
      exp_reg        <= '0;
      sig_reg        <= '0;
      sticky_reg     <= 1'b0;
      cnt_reg        <= '0;
      special_reg    <= 1'b0;
      spec_res_reg   <= '0;
      spec_flags_reg <= '0;
      tiny_reg       <= 1'b0;
      valid_o        <= 1'b0;
      result_o       <= '0;
      flags_o        <= '0;
    end else begin
      valid_o <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start_i) begin
            dir_reg   <= dir_i;
            op_reg    <= operand_i;
            rm_reg    <= (rm_i > 3'd4) ? 3'd0 : rm_i;
            state_reg <= UNPACK;
          end
        end
        UNPACK: begin
          sign_reg       <= u_sign;
          exp_reg        <= u_exp;
          sig_reg        <= u_sig;
          sticky_reg     <= 1'b0;
          cnt_reg        <= u_cnt;
          special_reg    <= u_special;
          spec_res_reg   <= u_res;
          spec_flags_reg <= u_flags;
          tiny_reg       <= u_tiny;
          state_reg      <= (!u_special && u_shift) ? SHIFT : ROUND;
        end
        SHIFT: begin
          if (dir_reg) begin
            sig_reg <= sig_reg << 1;
            exp_reg <= exp_reg - 13'sd1;
            if (sig_reg[51]) state_reg <= ROUND;
          end else begin
            sig_reg    <= sig_reg >> 1;
            sticky_reg <= sticky_reg | sig_reg[0];
            exp_reg    <= exp_reg + 13'sd1;
            cnt_reg    <= cnt_reg - 5'd1;
            if (cnt_reg == 5'd1) state_reg <= ROUND;
          end
        end
        ROUND: begin
          result_o  <= special_reg ? spec_res_reg : r_res;
          flags_o   <= special_reg ? spec_flags_reg : r_flags;
          valid_o   <= 1'b1;
          state_reg <= DONE;
        end
        DONE: state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign busy_o = (state_reg != IDLE);

endmodule

// File: tb/tb_fcvt_sd.sv
// Scoreboard bench for fcvt_sd: directed vectors push expectations, a forked monitor
// pops and checks result, flags and start-to-valid latency on every valid_o pulse.
module tb_fcvt_sd;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        dir;
  logic [63:0] operand;
  logic [2:0]  rm;
  logic        busy;
  logic        valid;
  logic [63:0] result;
  logic [4:0]  flags;

  localparam logic [4:0] NV = 5'b10000;
  localparam logic [4:0] OF = 5'b00100;
  localparam logic [4:0] UF = 5'b00010;
  localparam logic [4:0] NX = 5'b00001;

  typedef struct {
    logic [63:0] res;
    logic [4:0]  flg;
    int          lat;
    int          t0;
  } exp_t;

  exp_t  sb[$];
  string nameq[$];
  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;

  fcvt_sd dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .start_i  (start),
    .dir_i    (dir),
    .operand_i(operand),
    .rm_i     (rm),
    .busy_o   (busy),
    .valid_o  (valid),
    .result_o (result),
    .flags_o  (flags)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  task automatic monitor_loop();
    exp_t  e;
    string n;
    forever begin
      @(negedge clk);
      if (valid === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid: got valid_o=1 want no pending transaction");
        end else begin
          e = sb.pop_front();
          n = nameq.pop_front();
          chk({n, ".result"}, result, e.res);
          chk({n, ".flags"}, {59'b0, flags}, {59'b0, e.flg});
          chk({n, ".latency"}, 64'(cyc - e.t0), 64'(e.lat));
          $display("%s: result %h flags %b latency %0d", n, result, flags, cyc - e.t0);
        end
      end
    end
  endtask

  task automatic run(input string name, input logic d, input logic [63:0] op, input logic [2:0] r,
                     input logic [63:0] eres, input logic [4:0] eflg, input int elat,
                     input bit poke);
    int n;
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      @(posedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    sb.push_back('{eres, eflg, elat, cyc});
    nameq.push_back(name);
    start = 1'b1; dir = d; operand = op; rm = r;
    @(posedge clk);
    #1;
    start = 1'b0; dir = ~d; operand = 64'hDEADBEEF01234567; rm = 3'd3;
    if (poke) begin
      repeat (5) @(posedge clk);
      #1;
      start = 1'b1; dir = 1'b0; operand = 64'h7FF0000000000001;
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s.timeout: got no valid_o within 200 cycles want one", name);
      sb.delete();
      nameq.delete();
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; dir = 1'b0; operand = '0; rm = '0;
    fork
      monitor_loop();
    join_none
    repeat (2) @(posedge clk);
    #1;
    chk("reset.busy", {63'b0, busy}, 64'd0);
    chk("reset.valid", {63'b0, valid}, 64'd0);
    chk("reset.result", result, 64'd0);
    chk("reset.flags", {59'b0, flags}, 64'd0);
    rst = 1'b0;

    run("widen_one",      1'b1, 64'hFFFFFFFF3F800000, 3'd0, 64'h3FF0000000000000, 5'b0,    3, 1'b0);
    run("narrow_rne",     1'b0, 64'h3FF0000000000001, 3'd0, 64'hFFFFFFFF3F800000, NX,      3, 1'b0);
    run("narrow_rup",     1'b0, 64'h3FF0000000000001, 3'd3, 64'hFFFFFFFF3F800001, NX,      3, 1'b0);
    run("narrow_rm5",     1'b0, 64'h3FF0000000000001, 3'd5, 64'hFFFFFFFF3F800000, NX,      3, 1'b0);
    run("ovf_rne",        1'b0, 64'h7E37E43C8800759C, 3'd0, 64'hFFFFFFFF7F800000, OF | NX, 3, 1'b0);
    run("ovf_rtz",        1'b0, 64'h7E37E43C8800759C, 3'd1, 64'hFFFFFFFF7F7FFFFF, OF | NX, 3, 1'b0);
    run("ovf_rdn_pos",    1'b0, 64'h7E37E43C8800759C, 3'd2, 64'hFFFFFFFF7F7FFFFF, OF | NX, 3, 1'b0);
    run("ovf_rup_neg",    1'b0, 64'hFE37E43C8800759C, 3'd3, 64'hFFFFFFFFFF7FFFFF, OF | NX, 3, 1'b0);
    run("ovf_by_round",   1'b0, 64'h47EFFFFFF0000000, 3'd0, 64'hFFFFFFFF7F800000, OF | NX, 3, 1'b0);
    run("round_carry",    1'b0, 64'h3FFFFFFFF0000000, 3'd0, 64'hFFFFFFFF40000000, NX,      3, 1'b0);
    run("widen_subnorm",  1'b1, 64'hFFFFFFFF00000001, 3'd0, 64'h36A0000000000000, 5'b0,   26, 1'b1);
    run("narrow_min_sub", 1'b0, 64'h36A0000000000000, 3'd0, 64'hFFFFFFFF00000001, 5'b0,   26, 1'b0);
    run("narrow_uf",      1'b0, 64'h36A8000000000000, 3'd0, 64'hFFFFFFFF00000002, UF | NX,26, 1'b0);
    run("narrow_dsub",    1'b0, 64'h0000000000000001, 3'd3, 64'hFFFFFFFF00000001, UF | NX,28, 1'b0);
    run("narrow_snan",    1'b0, 64'h7FF0000000000001, 3'd0, 64'hFFFFFFFF7FC00000, NV,      3, 1'b0);
    run("narrow_qnan",    1'b0, 64'h7FF8000000000000, 3'd0, 64'hFFFFFFFF7FC00000, 5'b0,    3, 1'b0);
    run("widen_unboxed",  1'b1, 64'h000000003F800000, 3'd0, 64'h7FF8000000000000, 5'b0,    3, 1'b0);
    run("narrow_neginf",  1'b0, 64'hFFF0000000000000, 3'd0, 64'hFFFFFFFFFF800000, 5'b0,    3, 1'b0);
    run("narrow_negzero", 1'b0, 64'h8000000000000000, 3'd0, 64'hFFFFFFFF80000000, 5'b0,    3, 1'b0);
    run("widen_neginf",   1'b1, 64'hFFFFFFFFFF800000, 3'd0, 64'hFFF0000000000000, 5'b0,    3, 1'b0);

    // Abort a long widening mid-shift; nothing is queued so any valid_o is flagged.
    @(posedge clk);
    #1;
    start = 1'b1; dir = 1'b1; operand = 64'hFFFFFFFF00000001; rm = 3'd0;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (6) @(posedge clk);
    #2;
    chk("abort.busy_before", {63'b0, busy}, 64'd1);
    rst = 1'b1;
    #1;
    chk("abort.busy", {63'b0, busy}, 64'd0);
    chk("abort.valid", {63'b0, valid}, 64'd0);
    chk("abort.result", result, 64'd0);
    chk("abort.flags", {59'b0, flags}, 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (35) @(posedge clk);
    run("after_reset", 1'b1, 64'hFFFFFFFF3F800000, 3'd0, 64'h3FF0000000000000, 5'b0, 3, 1'b0);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
